// File: rtl/processing_element_if.sv
// Operand and result bundle for one ternary processing element.
// The master drives weight/activation/partial-sum inputs; the slave is the PE.
interface processing_element_if #(
  parameter int IF_BITWIDTH = 8,
  parameter int OF_BITWIDTH = 16
);
  logic                          enable;
  logic                          weight_read;
  logic [1:0]                    weight_in;
  logic signed [IF_BITWIDTH-1:0] data_in;
  logic signed [IF_BITWIDTH-1:0] psum_in;
  logic signed [OF_BITWIDTH-1:0] data_out;

  modport master (
    output enable, weight_read, weight_in, data_in, psum_in,
    input  data_out
  );

  modport slave (
    input  enable, weight_read, weight_in, data_in, psum_in,
    output data_out
  );
endinterface

// File: rtl/processing_element.sv
// Ternary-weight MAC cell: data_out <= psum_in + w*data_in, w in {-1,0,+1}, no multiplier.
// Latency 1 cycle, one result per cycle, no backpressure (enable=0 simply holds data_out).
// Optional PE_SATURATE_EN clamps the result to the OF_BITWIDTH range instead of wrapping.
module processing_element #(
  parameter int IF_BITWIDTH = 8,
  parameter int OF_BITWIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  processing_element_if.slave   pe
);
  localparam int SW = OF_BITWIDTH + 1;

  localparam logic signed [OF_BITWIDTH-1:0] OUT_MAX = {1'b0, {(OF_BITWIDTH-1){1'b1}}};
  localparam logic signed [OF_BITWIDTH-1:0] OUT_MIN = {1'b1, {(OF_BITWIDTH-1){1'b0}}};

  logic [1:0]                    weight_q;
  logic [1:0]                    w_eff;
  logic signed [SW-1:0]          psum_ext;
  logic signed [SW-1:0]          data_ext;
  logic signed [SW-1:0]          product;
  logic signed [SW-1:0]          sum;
  logic signed [OF_BITWIDTH-1:0] sum_narrow;
  logic signed [OF_BITWIDTH-1:0] data_q;

  // A freshly presented weight is usable in the same cycle it is loaded.
  assign w_eff = pe.weight_read ? pe.weight_in : weight_q;

  // One spare bit above OF makes -(-2^(IF-1)) and the add exact, since OF >= IF.
  assign psum_ext = {{(SW-IF_BITWIDTH){pe.psum_in[IF_BITWIDTH-1]}}, pe.psum_in};
  assign data_ext = {{(SW-IF_BITWIDTH){pe.data_in[IF_BITWIDTH-1]}}, pe.data_in};

  always_comb begin
    product = '0;
    case (w_eff)
      2'b01:   product = data_ext;
      2'b11:   product = -data_ext;
      default: product = '0;  // 2'b00 and the illegal 2'b10 both contribute nothing
    endcase
  end

  assign sum = psum_ext + product;

`ifdef PE_SATURATE_EN
  // The top two bits differ exactly when sum lies outside the OF-bit signed range.
  always_comb begin
    sum_narrow = sum[OF_BITWIDTH-1:0];
    if (sum[SW-1] != sum[SW-2]) begin
      sum_narrow = sum[SW-1] ? OUT_MIN : OUT_MAX;
    end
  end
`else
  always_comb begin
    sum_narrow = sum[OF_BITWIDTH-1:0];
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      weight_q <= 2'b00;
      data_q   <= '0;
    end else begin
      if (pe.weight_read) begin
        weight_q <= pe.weight_in;
      end
      if (pe.enable) begin
        data_q <= sum_narrow;
      end
    end
  end

  assign pe.data_out = data_q;

endmodule

// File: tb/tb_processing_element.sv
// Directed check of the ternary PE: a default 16-bit-output instance and an 8-bit-output
// instance for the wrap/clamp boundary, expectations matching the PE_SATURATE_EN build.
module tb_processing_element;
  logic clock;
  logic reset;
  int   n_tests;
  int   n_fail;

  processing_element_if #(.IF_BITWIDTH(8), .OF_BITWIDTH(16)) pe16_if ();
  processing_element_if #(.IF_BITWIDTH(8), .OF_BITWIDTH(8))  pe8_if ();

  processing_element #(.IF_BITWIDTH(8), .OF_BITWIDTH(16)) u_pe16 (
    .clock (clock),
    .reset (reset),
    .pe    (pe16_if.slave)
  );

  processing_element #(.IF_BITWIDTH(8), .OF_BITWIDTH(8)) u_pe8 (
    .clock (clock),
    .reset (reset),
    .pe    (pe8_if.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Apply one vector to the 16-bit PE, clock it, sample 1 time unit after the edge.
  task automatic drive16(input logic en, input logic wr, input logic [1:0] w,
                         input int d, input int p);
    logic [31:0] dv;
    logic [31:0] pv;
    dv = d;
    pv = p;
    pe16_if.enable      = en;
    pe16_if.weight_read = wr;
    pe16_if.weight_in   = w;
    pe16_if.data_in     = dv[7:0];
    pe16_if.psum_in     = pv[7:0];
    @(posedge clock);
    #1;
  endtask

  task automatic drive8(input logic en, input logic wr, input logic [1:0] w,
                        input int d, input int p);
    logic [31:0] dv;
    logic [31:0] pv;
    dv = d;
    pv = p;
    pe8_if.enable      = en;
    pe8_if.weight_read = wr;
    pe8_if.weight_in   = w;
    pe8_if.data_in     = dv[7:0];
    pe8_if.psum_in     = pv[7:0];
    @(posedge clock);
    #1;
  endtask

  initial begin
    int exp_a;
    int exp_b;
    n_tests = 0;
    n_fail  = 0;
    pe16_if.enable = 1'b0; pe16_if.weight_read = 1'b0; pe16_if.weight_in = 2'b00;
    pe16_if.data_in = '0;  pe16_if.psum_in = '0;
    pe8_if.enable  = 1'b0; pe8_if.weight_read  = 1'b0; pe8_if.weight_in  = 2'b00;
    pe8_if.data_in  = '0;  pe8_if.psum_in  = '0;

    // Reset with enable/weight_read asserted: reset must win.
    reset = 1'b1;
    pe8_if.enable = 1'b1;
    drive16(1'b1, 1'b1, 2'b01, 9, 9);
    check_val("reset16", int'(pe16_if.data_out), 0);
    check_val("reset8",  int'(pe8_if.data_out), 0);
    reset = 1'b0;
    pe8_if.enable = 1'b0;

    // Load -1 and use it in the same cycle.
    drive16(1'b1, 1'b1, 2'b11, 1, 1);
    check_val("t1_same_cycle_load", int'(pe16_if.data_out), 0);

    drive16(1'b1, 1'b1, 2'b00, 2, 3);
    check_val("t2_w0", int'(pe16_if.data_out), 3);
    drive16(1'b1, 1'b1, 2'b01, 3, 5);
    check_val("t2_wp1", int'(pe16_if.data_out), 8);
    drive16(1'b1, 1'b1, 2'b01, 120, -10);
    check_val("t2_wp1_negp", int'(pe16_if.data_out), 110);
    drive16(1'b1, 1'b1, 2'b11, 121, 12);
    check_val("t2_wm1", int'(pe16_if.data_out), -109);
    drive16(1'b1, 1'b1, 2'b01, -122, -2);
    check_val("t2_negd", int'(pe16_if.data_out), -124);

    // Stored weight versus ignored weight_in, and the illegal encoding.
    drive16(1'b1, 1'b1, 2'b01, 0, 0);
    check_val("t3_load", int'(pe16_if.data_out), 0);
    drive16(1'b1, 1'b0, 2'b11, 7, 1);
    check_val("t3_stored_w", int'(pe16_if.data_out), 8);
    drive16(1'b1, 1'b1, 2'b10, 9, 4);
    check_val("t3_illegal_live", int'(pe16_if.data_out), 4);
    drive16(1'b1, 1'b0, 2'b01, 9, 4);
    check_val("t3_illegal_stored", int'(pe16_if.data_out), 4);

    // Hold while disabled; weight_read still loads while enable=0.
    drive16(1'b1, 1'b1, 2'b01, 40, 10);
    check_val("t4_set50", int'(pe16_if.data_out), 50);
    for (int i = 0; i < 3; i++) begin
      drive16(1'b0, 1'b0, 2'b11, 100, -3);
      check_val("t4_hold", int'(pe16_if.data_out), 50);
    end
    drive16(1'b0, 1'b1, 2'b11, 100, -3);
    check_val("t4_hold_wload", int'(pe16_if.data_out), 50);
    drive16(1'b1, 1'b0, 2'b01, 100, -3);
    check_val("t4_reenable", int'(pe16_if.data_out), -103);

    // Most negative activation and extreme partial sums.
    drive16(1'b1, 1'b1, 2'b11, -128, -128);
    check_val("edge_neg_min_pmin", int'(pe16_if.data_out), 0);
    drive16(1'b1, 1'b1, 2'b11, -128, 127);
    check_val("edge_neg_min_pmax", int'(pe16_if.data_out), 255);
    drive16(1'b1, 1'b1, 2'b01, -128, -128);
    check_val("edge_min_plus_min", int'(pe16_if.data_out), -256);

    // Mid-run reset clears output and weight; output resumes afterwards.
    drive16(1'b1, 1'b1, 2'b01, 5, 5);
    check_val("t5_pre", int'(pe16_if.data_out), 10);
    reset = 1'b1;
    drive16(1'b1, 1'b1, 2'b01, 5, 5);
    check_val("t5_reset", int'(pe16_if.data_out), 0);
    reset = 1'b0;
    drive16(1'b1, 1'b0, 2'b01, 5, 0);
    check_val("t5_weight_cleared", int'(pe16_if.data_out), 0);
    drive16(1'b1, 1'b1, 2'b01, 5, 0);
    check_val("t5_resume", int'(pe16_if.data_out), 5);

    // Narrow output: overflow wraps or clamps depending on the build.
`ifdef PE_SATURATE_EN
    exp_a = 127;
    exp_b = 127;
`else
    exp_a = -2;
    exp_b = -128;
`endif
    drive8(1'b1, 1'b1, 2'b01, 127, 127);
    check_val("t6_pos_ovf", int'(pe8_if.data_out), exp_a);
    drive8(1'b1, 1'b1, 2'b11, -128, 0);
    check_val("t6_neg_min", int'(pe8_if.data_out), exp_b);
    drive8(1'b1, 1'b1, 2'b01, 100, 20);
    check_val("t6_in_range", int'(pe8_if.data_out), 120);
`ifdef PE_SATURATE_EN
    exp_a = -128;
`else
    exp_a = 126;
`endif
    drive8(1'b1, 1'b1, 2'b01, -128, -2);
    check_val("t6_neg_ovf", int'(pe8_if.data_out), exp_a);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
